// File: rtl/pci_phy_pkg.sv
// pci_phy_pkg: shared widths, serializer state encoding and byte selection for the PCI PHY datapath.
package pci_phy_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int BYTES  = WORD_W / BYTE_W;
  typedef enum logic [1:0] {FREE = 2'd0, B1 = 2'd1, B2 = 2'd2, B3 = 2'd3} state_t;
  function automatic logic [BYTE_W-1:0] byte_sel(input logic [WORD_W-1:0] w, input logic [1:0] k, input logic msb_first);
    int s;
    s = msb_first ? BYTE_W * (BYTES - 1 - int'(k)) : BYTE_W * int'(k);
    return w[s +: BYTE_W];
  endfunction
endpackage

// File: rtl/mux_32_8.sv
// mux_32_8: word-to-byte serializer with a one-word hold register so words stream back to back.
module mux_32_8
  import pci_phy_pkg::*;
#(
  parameter logic [BYTE_W-1:0] IDLE_BYTE = 8'h00,
  parameter bit                MSB_FIRST = 1'b1
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic [WORD_W-1:0] data_in,
  input  logic              valid_in,
  output logic              ready_out,
  output logic [BYTE_W-1:0] data_out,
  output logic              valid_out,
  output logic              sop_out
);
  state_t state, state_nx;
  logic [WORD_W-1:0] cur, cur_nx, hold, hold_nx, next_word;
  logic [BYTE_W-1:0] data_nx;
  logic hold_v, hold_v_nx, valid_nx, sop_nx, xfer, start, free;
  assign ready_out = reset & ~hold_v;
  assign xfer = valid_in & ready_out;
  assign free = state == FREE;
  // a pending hold word always wins the FREE edge; input is blocked then since ready_out=0
  always_comb begin
    next_word = hold_v ? hold : data_in;
    start     = free & (hold_v | xfer);
    state_nx  = (free & ~start) ? FREE : state_t'(state + 2'd1);
    cur_nx    = start ? next_word : cur;
    hold_nx   = (xfer & ~free) ? data_in : hold;
    hold_v_nx = (xfer & ~free) | (hold_v & ~free);
    valid_nx  = start | ~free;
    sop_nx    = start;
    data_nx   = start ? byte_sel(next_word, 2'd0, MSB_FIRST) :
                free  ? IDLE_BYTE : byte_sel(cur, state, MSB_FIRST);
  end
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      state     <= FREE;
      cur       <= '0;
      hold      <= '0;
      hold_v    <= 1'b0;
      data_out  <= IDLE_BYTE;
      valid_out <= 1'b0;
      sop_out   <= 1'b0;
    end else begin
      state     <= state_nx;
      cur       <= cur_nx;
      hold      <= hold_nx;
      hold_v    <= hold_v_nx;
      data_out  <= data_nx;
      valid_out <= valid_nx;
      sop_out   <= sop_nx;
    end
  end
endmodule

// File: tb/tb_mux_32_8.sv
// tb_mux_32_8: randomized and directed checks of both byte orders against a word-queue model.
module tb_mux_32_8;
  logic clk_4f = 1'b0;
  logic reset = 1'b1;
  logic [31:0] data_in = '0;
  logic valid_in = 1'b0;
  logic ready_m, valid_m, sop_m, ready_l, valid_l, sop_l;
  logic [7:0] data_m, data_l;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] q[$];
  logic [31:0] cur;
  int pos;
  logic ev, es;
  always #5 clk_4f = ~clk_4f;
  mux_32_8 #(.IDLE_BYTE(8'h00), .MSB_FIRST(1'b1)) u_msb (
    .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_m), .data_out(data_m), .valid_out(valid_m), .sop_out(sop_m));
  mux_32_8 #(.IDLE_BYTE(8'h00), .MSB_FIRST(1'b0)) u_lsb (
    .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
    .ready_out(ready_l), .data_out(data_l), .valid_out(valid_l), .sop_out(sop_l));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_rst();
    q.delete();
    cur = '0;
    pos = 3;
    ev = 1'b0;
    es = 1'b0;
  endtask
  // a word is accepted only when nothing is queued; bytes 0..3 of the current word go out one per edge
  task automatic model_edge();
    if (valid_in && q.size() == 0) q.push_back(data_in);
    if (pos < 3) begin
      pos++;
      ev = 1'b1;
      es = 1'b0;
    end else if (q.size() != 0) begin
      cur = q.pop_front();
      pos = 0;
      ev = 1'b1;
      es = 1'b1;
    end else begin
      ev = 1'b0;
      es = 1'b0;
    end
  endtask
  task automatic check_outs();
    logic [7:0] em, el;
    logic er;
    em = ev ? 8'((cur >> (8 * (3 - pos))) & 32'hFF) : 8'h00;
    el = ev ? 8'((cur >> (8 * pos)) & 32'hFF) : 8'h00;
    er = reset && q.size() == 0;
    chk("ready_m", ready_m, er);
    chk("ready_l", ready_l, er);
    chk("valid_m", valid_m, ev);
    chk("valid_l", valid_l, ev);
    chk("sop_m", sop_m, es);
    chk("sop_l", sop_l, es);
    chk("data_m", data_m, em);
    chk("data_l", data_l, el);
  endtask
  task automatic cyc(input logic v, input logic [31:0] d);
    valid_in = v;
    data_in = d;
    @(posedge clk_4f);
    if (reset) model_edge();
    @(negedge clk_4f);
    check_outs();
  endtask
  task automatic rst_pulse(input int n);
    reset = 1'b0;
    #1;
    model_rst();
    check_outs();
    for (int i = 0; i < n; i++) cyc(1'b0, 32'hDEADBEEF);
    reset = 1'b1;
  endtask
  initial begin
    #2;
    rst_pulse(2);
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0);
    cyc(1'b1, 32'hEEFFFDCC);
    chk("sw_b0", data_m, 8'hEE);
    chk("sw_sop", sop_m, 1'b1);
    chk("sw_lsb_b0", data_l, 8'hCC);
    cyc(1'b0, 32'h0);
    chk("sw_b1", data_m, 8'hFF);
    cyc(1'b0, 32'h0);
    chk("sw_b2", data_m, 8'hFD);
    cyc(1'b0, 32'h0);
    chk("sw_b3", data_m, 8'hCC);
    chk("sw_lsb_b3", data_l, 8'hEE);
    cyc(1'b0, 32'h0);
    chk("sw_idle", valid_m, 1'b0);
    cyc(1'b1, 32'hAA12BB00);
    cyc(1'b1, 32'h11223344);
    chk("bb_ready", ready_m, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h55667788);
    chk("bb_b0", data_m, 8'h11);
    chk("bb_sop", sop_m, 1'b1);
    for (int i = 0; i < 8; i++) cyc(1'b0, 32'h0);
    cyc(1'b1, 32'hEEFFFDCC);
    cyc(1'b1, 32'hCAFEF00D);
    rst_pulse(2);
    chk("mid_idle", valid_m, 1'b0);
    cyc(1'b0, 32'h0);
    cyc(1'b1, 32'h01020304);
    chk("post_b0", data_m, 8'h01);
    for (int i = 0; i < 4; i++) cyc(1'b0, 32'h0);
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) rst_pulse($urandom_range(0, 2));
      cyc($urandom_range(0, 9) < 7, $urandom);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
